// File: rtl/add_pipe_pkg.sv
// rtl/add_pipe_pkg.sv - shared types and helpers for the pipelined adder/subtractor
package add_pipe_pkg;

  // Per-stage control bits; operand and partial-result slices live in width-parametrised arrays.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  function automatic int num_stages(input int n, input int chunk);
    return n / chunk;
  endfunction

`ifdef ADD_PIPE_SAT_EN
  localparam int SAT_W = 1024;
  localparam logic [SAT_W-1:0] SAT_MAX_W = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic [SAT_W-1:0] SAT_MIN_W = {1'b1, {(SAT_W-1){1'b0}}};
`endif

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational W-bit ripple adder exposing carry into its MSB
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] ina,
  input  logic [W-1:0] inb,
  input  logic         ci,
  output logic [W-1:0] out,
  output logic         co,
  output logic         msb_ci
);

  logic [W:0] c;

  always_comb begin
    c = {{W{1'b0}}, ci};
    for (int i = 0; i < W; i++) begin
      c[i+1] = (ina[i] & inb[i]) | (c[i] & (ina[i] ^ inb[i]));
    end
  end

  assign out    = ina ^ inb ^ c[W-1:0];
  assign co     = c[W];
  assign msb_ci = c[W-1];

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined N-bit add/sub, one CHUNK slice per stage, valid/ready on both sides
// Optional saturating output when ADD_PIPE_SAT_EN is defined.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ina,
  input  logic [N-1:0] inb,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         co,
  output logic         ovf
);

  localparam int STAGES = num_stages(N, CHUNK);

  stage_ctl_t   ctl_q [STAGES];
  stage_ctl_t   ctl_d [STAGES];
  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] r_q   [STAGES];
  logic [N-1:0] a_d   [STAGES];
  logic [N-1:0] b_d   [STAGES];
  logic [N-1:0] r_d   [STAGES];
  logic         adv;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv = !ctl_q[STAGES-1].valid || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_i;
    logic             s_i;
    logic             c_i;
    logic [N-1:0]     a_i;
    logic [N-1:0]     b_i;
    logic [N-1:0]     r_o;
    logic [N-1:0]     r_f;
    logic [CHUNK-1:0] sum;
    logic             c_o;
    logic             c_m;

    if (k == 0) begin : g_head
      // B is inverted once on entry, so later stages never need the sub flag.
      assign v_i = in_valid;
      assign s_i = sub;
      assign c_i = sub | ci;
      assign a_i = ina;
      assign b_i = sub ? ~inb : inb;
      always_comb begin
        r_o            = '0;
        r_o[CHUNK-1:0] = sum;
      end
    end else begin : g_body
      assign v_i = ctl_q[k-1].valid;
      assign s_i = ctl_q[k-1].sub;
      assign c_i = ctl_q[k-1].carry;
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      always_comb begin
        r_o                    = r_q[k-1];
        r_o[k*CHUNK +: CHUNK]  = sum;
      end
    end

    add_chunk #(.W(CHUNK)) u_chunk (
      .ina    (a_i[k*CHUNK +: CHUNK]),
      .inb    (b_i[k*CHUNK +: CHUNK]),
      .ci     (c_i),
      .out    (sum),
      .co     (c_o),
      .msb_ci (c_m)
    );

`ifdef ADD_PIPE_SAT_EN
    if (k == STAGES - 1) begin : g_sat
      always_comb begin
        r_f = r_o;
        if (c_m ^ c_o) begin
          r_f = (!a_i[N-1] && !b_i[N-1]) ? SAT_MAX_W[SAT_W-1 -: N] : SAT_MIN_W[SAT_W-1 -: N];
        end
      end
    end else begin : g_nosat
      assign r_f = r_o;
    end
`else
    assign r_f = r_o;
`endif

    assign ctl_d[k] = '{valid: v_i, sub: s_i, carry: c_o, ovf: c_m ^ c_o};
    assign a_d[k]   = a_i;
    assign b_d[k]   = b_i;
    assign r_d[k]   = r_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        r_q[k]   <= r_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = ctl_q[STAGES-1].valid;
  assign out       = r_q[STAGES-1];
  assign co        = ctl_q[STAGES-1].carry;
  assign ovf       = ctl_q[STAGES-1].ovf;

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - scoreboard bench for add_pipe at 32/8, 32/32 and 64/16
module tb_add_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] ina;
  logic [63:0] inb;
  logic        ci;
  logic        sub;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] out0, out1;
  logic [63:0] out2;
  logic        co0, co1, co2;
  logic        ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_mode = 0;
  bit after_rst = 0;

  int stg [3] = '{4, 1, 4};
  int wid [3] = '{32, 32, 64};

  logic [65:0] exp_q [3][$];
  int          acc_q [3][$];
  bit          hold  [3];
  logic [65:0] held  [3];
  logic        ovs   [3];
  logic        irs   [3];
  logic [65:0] gots  [3];

  add_pipe #(.N(32), .CHUNK(8)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .ina(ina[31:0]), .inb(inb[31:0]), .ci(ci), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .out(out0), .co(co0), .ovf(ovf0)
  );

  add_pipe #(.N(32), .CHUNK(32)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .ina(ina[31:0]), .inb(inb[31:0]), .ci(ci), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .out(out1), .co(co1), .ovf(ovf1)
  );

  add_pipe #(.N(64), .CHUNK(16)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .ina(ina), .inb(inb), .ci(ci), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .out(out2), .co(co2), .ovf(ovf2)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain (n+1)-bit arithmetic, overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s, input int n);
    logic [64:0] mask, aa, bb, sum;
    logic [63:0] o;
    logic        cy, ov;
    mask = (65'd1 << n) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    sum  = aa + bb + (s ? 65'd1 : {64'd0, c});
    cy   = sum[n];
    o    = sum[63:0] & mask[63:0];
    ov   = (aa[n-1] == bb[n-1]) && (o[n-1] != aa[n-1]);
`ifdef ADD_PIPE_SAT_EN
    if (ov) o = aa[n-1] ? (64'd1 << (n-1)) : ((64'd1 << (n-1)) - 64'd1);
`endif
    return {ov, cy, o};
  endfunction

  task automatic check(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  always begin : compare
    @(negedge clk);
    #3;
    ovs  = '{ov0, ov1, ov2};
    irs  = '{ir0, ir1, ir2};
    gots[0] = {ovf0, co0, 32'd0, out0};
    gots[1] = {ovf1, co1, 32'd0, out1};
    gots[2] = {ovf2, co2, out2};
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        acc_q[i].delete();
        hold[i] = 0;
      end
      after_rst = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (after_rst) check("reset_state", i, {ovs[i], irs[i], gots[i]}, {1'b0, 1'b1, 66'd0});
        check("in_ready", i, irs[i], !ovs[i] || out_ready);
        if (hold[i]) check("hold_stable", i, {ovs[i], gots[i]}, {1'b1, held[i]});
        if (ovs[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out dut%0d: got %0h expected no beat", i, gots[i]);
          end else begin
            int a;
            check("result", i, gots[i], exp_q[i].pop_front());
            a = acc_q[i].pop_front();
            if (lat_mode) check("latency", i, cyc - a, stg[i]);
          end
        end
        if (in_valid && irs[i]) begin
          exp_q[i].push_back(model(ina, inb, ci, sub, wid[i]));
          acc_q[i].push_back(cyc);
        end
        hold[i] = ovs[i] && !out_ready;
        held[i] = gots[i];
      end
      after_rst = 0;
    end
  end

  task automatic direct(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                        input logic [31:0] eo, input logic eco, input logic eovf);
    int t0;
    bit found;
    @(negedge clk);
    ina = {32'd0, a}; inb = {32'd0, b}; ci = c; sub = s;
    in_valid = 1; out_ready = 1;
    t0 = cyc;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      in_valid = 0;
      #3;
      if (ov0) begin
        found = 1;
        check("lit_latency", 0, cyc - t0, 4);
        check("lit_out", 0, out0, eo);
        check("lit_co", 0, co0, eco);
        check("lit_ovf", 0, ovf0, eovf);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL lit_timeout dut0: got no out_valid expected one within 20 cycles");
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      in_valid = 0;
      out_ready = 1;
      #4;
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending expected 0", exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
    end
  endtask

  task automatic rand_beat(input bit v, input bit r);
    @(negedge clk);
    ina = {$urandom, $urandom};
    inb = {$urandom, $urandom};
    ci  = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    in_valid  = v;
    out_ready = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    rst = 1; in_valid = 0; out_ready = 1;
    ina = '0; inb = '0; ci = 0; sub = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    lat_mode = 1;

    direct(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    direct(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef ADD_PIPE_SAT_EN
    direct(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
    direct(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
    direct(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`ifdef ADD_PIPE_SAT_EN
    direct(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    direct(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    direct(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) rand_beat(1'b1, 1'b1);
    drain();

    lat_mode = 0;
    for (int i = 0; i < 1500; i++) rand_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    lat_mode = 1;

    for (int i = 0; i < 3; i++) rand_beat(1'b1, 1'b1);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) rand_beat(1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
